// File: rtl/scale_ratio_ctrl.sv
// Per-frame scaler configuration: samples requested destination size on vsync fall, computes
// X/Y ratios floor(SRC*2^F/DST) with one shared restoring divider, commits everything atomically.
module scale_ratio_ctrl #(
    parameter int C_SRC_IMG_WIDTH  = 640,
    parameter int C_SRC_IMG_HEIGHT = 480,
    parameter int C_DEF_DST_WIDTH  = 640,
    parameter int C_DEF_DST_HEIGHT = 480,
    parameter int C_FRAC_BITS      = 16
) (
    input  logic                   clk_in2,
    input  logic                   rst,
    input  logic                   per_img_vsync,
    input  logic [11:0]            c_dst_img_width,
    input  logic [11:0]            c_dst_img_height,
    output logic [11:0]            cfg_dst_width,
    output logic [11:0]            cfg_dst_height,
    output logic [C_FRAC_BITS:0]   cfg_x_ratio,
    output logic [C_FRAC_BITS:0]   cfg_y_ratio,
    output logic                   cfg_busy,
    output logic                   cfg_done,
    output logic                   cfg_err
);

    localparam int F  = C_FRAC_BITS;
    localparam int NW = 12 + F;
    localparam int CW = $clog2(NW);

    localparam logic [NW-1:0] NUM_X     = {12'(C_SRC_IMG_WIDTH), {F{1'b0}}};
    localparam logic [NW-1:0] NUM_Y     = {12'(C_SRC_IMG_HEIGHT), {F{1'b0}}};
    localparam logic [F:0]    RATIO_ONE = {1'b1, {F{1'b0}}};
    localparam logic [F:0]    RATIO_MAX = {(F+1){1'b1}};
    localparam logic [CW-1:0] CNT_LAST  = CW'(NW - 1);

    typedef enum logic [1:0] {IDLE, LATCH, DIV_X, DIV_Y} state_t;

    typedef struct packed {
        logic [11:0] w;
        logic [11:0] h;
    } size_t;

    state_t        state_q, state_d;
    logic          vs_q, vs_d;
    logic          fall_q, fall_d;
    logic          pending_q, pending_d;
    size_t         lat_q, lat_d;
    size_t         cfg_size_q, cfg_size_d;
    logic [NW-1:0] num_q, num_d;
    logic [12:0]   rem_q, rem_d;
    logic [NW-1:0] quo_q, quo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [F:0]    x_ratio_q, x_ratio_d;
    logic          x_err_q, x_err_d;
    logic [F:0]    cfg_x_q, cfg_x_d;
    logic [F:0]    cfg_y_q, cfg_y_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [11:0]   den;
    logic [13:0]   trial;
    logic          ge;
    logic [12:0]   step_rem;
    logic [NW-1:0] step_quo;
    logic          res_sat;
    logic [F:0]    res_ratio;

    // One restoring step: shift in next numerator bit, subtract if it fits.
    always_comb begin
        den       = (state_q == DIV_Y) ? lat_q.h : lat_q.w;
        trial     = {rem_q, num_q[NW-1]};
        ge        = trial >= {2'b00, den};
        step_rem  = ge ? 13'(trial - {2'b00, den}) : 13'(trial);
        step_quo  = NW'({quo_q, ge});
        res_sat   = (den == 12'd0) || (|step_quo[NW-1:F+1]);
        res_ratio = res_sat ? RATIO_MAX : step_quo[F:0];
    end

    always_comb begin
        state_d    = state_q;
        vs_d       = per_img_vsync;
        fall_d     = vs_q & ~per_img_vsync;
        pending_d  = pending_q;
        lat_d      = lat_q;
        cfg_size_d = cfg_size_q;
        num_d      = num_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        x_ratio_d  = x_ratio_q;
        x_err_d    = x_err_q;
        cfg_x_d    = cfg_x_q;
        cfg_y_d    = cfg_y_q;
        done_d     = 1'b0;
        err_d      = err_q;

        if (fall_q && state_q != IDLE)
            pending_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (fall_q || pending_q) begin
                    state_d   = LATCH;
                    pending_d = 1'b0;
                end
            end
            LATCH: begin
                lat_d.w = c_dst_img_width;
                lat_d.h = c_dst_img_height;
                num_d   = NUM_X;
                rem_d   = '0;
                quo_d   = '0;
                cnt_d   = '0;
                if (c_dst_img_width == cfg_size_q.w && c_dst_img_height == cfg_size_q.h)
                    state_d = IDLE;
                else
                    state_d = DIV_X;
            end
            DIV_X, DIV_Y: begin
                num_d = num_q << 1;
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    num_d = NUM_Y;
                    rem_d = '0;
                    quo_d = '0;
                    cnt_d = '0;
                    if (state_q == DIV_X) begin
                        x_ratio_d = res_ratio;
                        x_err_d   = res_sat;
                        state_d   = DIV_Y;
                    end else begin
                        // Commit happens on the final Y step so no partial result ever leaks.
                        cfg_size_d = lat_q;
                        cfg_x_d    = x_ratio_q;
                        cfg_y_d    = res_ratio;
                        err_d      = x_err_q | res_sat;
                        done_d     = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in2) begin
        if (rst) begin
            state_q    <= IDLE;
            vs_q       <= 1'b0;
            fall_q     <= 1'b0;
            pending_q  <= 1'b0;
            lat_q      <= '0;
            cfg_size_q <= '{w: 12'(C_DEF_DST_WIDTH), h: 12'(C_DEF_DST_HEIGHT)};
            num_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            x_ratio_q  <= RATIO_ONE;
            x_err_q    <= 1'b0;
            cfg_x_q    <= RATIO_ONE;
            cfg_y_q    <= RATIO_ONE;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            vs_q       <= vs_d;
            fall_q     <= fall_d;
            pending_q  <= pending_d;
            lat_q      <= lat_d;
            cfg_size_q <= cfg_size_d;
            num_q      <= num_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            x_ratio_q  <= x_ratio_d;
            x_err_q    <= x_err_d;
            cfg_x_q    <= cfg_x_d;
            cfg_y_q    <= cfg_y_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign cfg_dst_width  = cfg_size_q.w;
    assign cfg_dst_height = cfg_size_q.h;
    assign cfg_x_ratio    = cfg_x_q;
    assign cfg_y_ratio    = cfg_y_q;
    assign cfg_busy       = (state_q != IDLE);
    assign cfg_done       = done_q;
    assign cfg_err        = err_q;

endmodule

// File: tb/tb_scale_ratio_ctrl.sv
// Directed bench for scale_ratio_ctrl: ratio values, commit latency, busy span, pending, reset abort.
module tb_scale_ratio_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        vsync;
    logic [11:0] req_w, req_h;
    logic [11:0] cfg_w, cfg_h;
    logic [16:0] cfg_x, cfg_y;
    logic        busy, done, err;

    int tests = 0;
    int fails = 0;
    int lat, busy_n;

    always #5 clk = ~clk;

    scale_ratio_ctrl dut (
        .clk_in2         (clk),
        .rst             (rst),
        .per_img_vsync   (vsync),
        .c_dst_img_width (req_w),
        .c_dst_img_height(req_h),
        .cfg_dst_width   (cfg_w),
        .cfg_dst_height  (cfg_h),
        .cfg_x_ratio     (cfg_x),
        .cfg_y_ratio     (cfg_y),
        .cfg_busy        (busy),
        .cfg_done        (done),
        .cfg_err         (err)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // vsync low for one cycle; returns at the sample where the fall is registered (k=0)
    task automatic vfall();
        vsync = 1'b0;
        step();
        vsync = 1'b1;
    endtask

    // latency in cycles from k=0 to done (or -1), counting busy samples before done
    task automatic wait_done(output int l, output int bn);
        l  = -1;
        bn = 0;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (done) begin
                l = k;
                break;
            end
            if (busy) bn++;
        end
    endtask

    task automatic chk_cfg(input string tag, input int w, input int h,
                           input int x, input int y, input int e);
        chk({tag, "_w"},   32'(cfg_w), 32'(w));
        chk({tag, "_h"},   32'(cfg_h), 32'(h));
        chk({tag, "_x"},   32'(cfg_x), 32'(x));
        chk({tag, "_y"},   32'(cfg_y), 32'(y));
        chk({tag, "_err"}, 32'(err),   32'(e));
    endtask

    initial begin
        rst   = 1'b1;
        vsync = 1'b1;
        req_w = 12'd640;
        req_h = 12'd480;
        repeat (3) step();
        rst = 1'b0;
        repeat (5) step();

        // 1: reset values hold
        chk_cfg("t1", 640, 480, 65536, 65536, 0);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_done", 32'(done), 0);

        // 2: 1280x720
        req_w = 12'd1280; req_h = 12'd720;
        vfall();
        chk("t2_busy_k0", 32'(busy), 0);
        wait_done(lat, busy_n);
        chk("t2_lat", 32'(lat), 58);
        chk("t2_busy_n", 32'(busy_n), 57);
        chk("t2_busy_at_done", 32'(busy), 0);
        chk_cfg("t2", 1280, 720, 32768, 43690, 0);
        step();
        chk("t2_done_pulse", 32'(done), 0);

        // 3: X saturates, then a clean request clears err
        req_w = 12'd160; req_h = 12'd480;
        vfall();
        wait_done(lat, busy_n);
        chk("t3a_lat", 32'(lat), 58);
        chk_cfg("t3a", 160, 480, 131071, 65536, 1);
        req_w = 12'd640; req_h = 12'd480;
        vfall();
        wait_done(lat, busy_n);
        chk_cfg("t3b", 640, 480, 65536, 65536, 0);

        // 4: zero width
        req_w = 12'd0; req_h = 12'd480;
        vfall();
        wait_done(lat, busy_n);
        chk("t4_lat", 32'(lat), 58);
        chk_cfg("t4", 0, 480, 131071, 65536, 1);

        // 5: second fall mid-run with a new request -> back-to-back runs
        req_w = 12'd1280; req_h = 12'd720;
        vfall();
        repeat (10) step();
        chk("t5_hold_x", 32'(cfg_x), 131071);
        chk("t5_hold_w", 32'(cfg_w), 0);
        req_w = 12'd320; req_h = 12'd240;
        vfall();
        wait_done(lat, busy_n);
        chk("t5_lat1", 32'(lat), 47);
        chk_cfg("t5a", 1280, 720, 32768, 43690, 0);
        wait_done(lat, busy_n);
        chk("t5_lat2", 32'(lat), 58);
        chk("t5_busy2", 32'(busy_n), 57);
        chk_cfg("t5b", 320, 240, 131071, 131071, 1);
        wait_done(lat, busy_n);
        chk("t5_no_third", 32'(lat), 32'(-1));
        chk("t5_idle", 32'(busy), 0);

        // 6: unchanged request -> one busy cycle, no done
        vfall();
        wait_done(lat, busy_n);
        chk("t6_no_done", 32'(lat), 32'(-1));
        chk("t6_busy_n", 32'(busy_n), 1);
        chk_cfg("t6a", 320, 240, 131071, 131071, 1);

        // 6b: reset during DIV_Y cycle 5 aborts and restores defaults
        req_w = 12'd1280; req_h = 12'd720;
        vfall();
        repeat (34) step();
        chk("t6_busy_mid", 32'(busy), 1);
        chk("t6_hold_x", 32'(cfg_x), 131071);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_cfg("t6r", 640, 480, 65536, 65536, 0);
        chk("t6r_busy", 32'(busy), 0);
        chk("t6r_done", 32'(done), 0);
        wait_done(lat, busy_n);
        chk("t6r_no_done", 32'(lat), 32'(-1));
        chk("t6r_busy_n", 32'(busy_n), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
